sfx_playback_sched: RTL and testbench

- Sequences sound-effect playback from a sample ROM into the audio CODEC write path.
- Game logic raises one-cycle triggers (bomb placed, explosion, death, ...). The block arbitrates the pending effects by fixed priority and walks the ROM address counter for the winning effect.
- Each sample is handed to the CODEC using the read_ready/write_ready handshake.
- While no effect is playing, the block releases the path so live passthrough audio is heard.

---
 rtl/sfx_pkg.sv | 39 +++
 rtl/sfx_playback_sched_prio_arb.sv | 25 ++
 rtl/sfx_playback_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_sfx_playback_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and tables for the sound-effect playback scheduler.
// Effect layout in the sample ROM is fixed here. Each effect must end below
// 2**SFX_ADDR_W so that playback never wraps through address zero.
package sfx_pkg;

    localparam int NUM_SFX_MAX   = 8;
    localparam int SFX_IDX_MAX_W = 3;
    localparam int SFX_ADDR_W    = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } sfx_state_t;

    // Named requester indices; a lower index wins arbitration.
    localparam int SFX_BOMB_PLACE = 0;
    localparam int SFX_EXPLODE    = 1;
    localparam int SFX_PICKUP     = 2;
    localparam int SFX_DEATH      = 3;

    // First ROM word of each effect.
    localparam logic [SFX_ADDR_W-1:0] SFX_BASE [NUM_SFX_MAX] = '{
        14'h0100, 14'h0200, 14'h0300, 14'h0400,
        14'h0800, 14'h0C00, 14'h1000, 14'h2000
    };

    // Number of ROM words per effect; zero is not a legal length.
    localparam logic [SFX_ADDR_W-1:0] SFX_LEN [NUM_SFX_MAX] = '{
        14'd3,  14'd2,  14'd4,  14'd2,
        14'd16, 14'd16, 14'd16, 14'd16
    };

    // Last ROM word used by an effect, handy when checking the table layout.
    function automatic logic [SFX_ADDR_W-1:0] sfx_last_addr(input int idx);
        return SFX_BASE[idx] + SFX_LEN[idx] - 14'd1;
    endfunction

endpackage

// File: rtl/sfx_playback_sched_prio_arb.sv
// Fixed-priority arbiter: the lowest set pending bit wins.
// Purely combinational; returns a one-hot grant, its binary index and a valid flag.
module sfx_prio_arb
    import sfx_pkg::*;
#(
    parameter int NUM_SFX = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SFX-1:0] pending,
    output logic [NUM_SFX-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    // Isolate the lowest set bit and encode its position.
    always_comb begin
        grant     = pending & (~pending + NUM_SFX'(1));
        grant_idx = {IDX_W{1'b0}};
        grant_vld = |pending;
        for (int i = 0; i < NUM_SFX; i++) begin
            grant_idx = grant_idx | (grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/sfx_playback_sched.sv
// Sound-effect playback scheduler.
// Latches one-cycle effect triggers, picks the highest-priority pending effect,
// walks its ROM words and hands each converted sample to the CODEC on the
// read/write-ready handshake. While idle the output mux selects passthrough.
//
// ROM timing: rom_data is sampled on the ROM_LAT-th rising edge after rom_addr
// is updated, so FETCH lasts exactly ROM_LAT cycles.
//
// Optional build macro: SFX_PREEMPT_EN -- when defined, a pending effect of
// higher priority aborts the current one at its next sample consumption.
// The aborted effect is dropped, not resumed.
module sfx_playback_sched
    import sfx_pkg::*;
#(
    parameter int NUM_SFX = 4,
    parameter int ADDR_W  = 14,
    parameter int ROM_LAT = 2,
    parameter int DATA_W  = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_SFX-1:0] sfx_trig,
    input  logic [2:0]         vol,
    input  logic               rw_ready,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [23:0]        sfx_sample,
    output logic               sfx_sel,
    output logic [NUM_SFX-1:0] sfx_busy
);

    localparam int IDX_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
    localparam int LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

    // Align a signed ROM word to the top of a 24-bit sample, then attenuate.
    function automatic logic [23:0] sfx_convert(input logic [DATA_W-1:0] word,
                                                input logic [2:0]        shamt);
        logic signed [23:0] ext;
        ext = 24'(signed'(word));
        ext = ext <<< (24 - DATA_W);
        return ext >>> shamt;
    endfunction

    sfx_state_t          state_r;
    sfx_state_t          state_nxt_s;
    logic [NUM_SFX-1:0]  pending_r;
    logic [NUM_SFX-1:0]  pend_clr_s;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic [ADDR_W-1:0]   remaining_r;
    logic [NUM_SFX-1:0]  sfx_busy_r;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic [23:0]         sfx_sample_r;
    logic                sfx_sel_r;

    logic [NUM_SFX-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_vld_s;
    logic [ADDR_W-1:0]   base_s;
    logic [ADDR_W-1:0]   len_s;

    logic                grant_s;
    logic                capture_s;
    logic                advance_s;
    logic                finish_s;

    sfx_prio_arb #(
        .NUM_SFX (NUM_SFX),
        .IDX_W   (IDX_W)
    ) u_arb (
        .pending   (pending_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .grant_vld (arb_vld_s)
    );

    // Look up the ROM window of the effect the arbiter currently favours.
    always_comb begin
        base_s = ADDR_W'(SFX_BASE[SFX_IDX_MAX_W'(arb_idx_s)]);
        len_s  = ADDR_W'(SFX_LEN[SFX_IDX_MAX_W'(arb_idx_s)]);
    end

`ifdef SFX_PREEMPT_EN
    logic lower_pend_s;

    // A pending index below the busy one; busy is one-hot so busy-1 masks the lower bits.
    always_comb begin
        lower_pend_s = |(pending_r & (sfx_busy_r - NUM_SFX'(1)));
    end
`endif

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        capture_s   = 1'b0;
        advance_s   = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_vld_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (lat_cnt_r == LAT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WAIT: begin
                if (rw_ready) begin
`ifdef SFX_PREEMPT_EN
                    if (lower_pend_s) begin
                        grant_s     = 1'b1;
                        state_nxt_s = FETCH;
                    end else if (remaining_r > ADDR_W'(1)) begin
                        advance_s   = 1'b1;
                        state_nxt_s = FETCH;
                    end else begin
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end
`else
                    if (remaining_r > ADDR_W'(1)) begin
                        advance_s   = 1'b1;
                        state_nxt_s = FETCH;
                    end else begin
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end
`endif
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pending bits to drop: only the effect granted this cycle.
    always_comb begin
        if (grant_s) begin
            pend_clr_s = arb_grant_s;
        end else begin
            pend_clr_s = {NUM_SFX{1'b0}};
        end
    end

    // Pending requests; a trigger in the grant cycle keeps its bit set for a replay.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending_r <= {NUM_SFX{1'b0}};
        end else begin
            pending_r <= (pending_r & ~pend_clr_s) | sfx_trig;
        end
    end

    // ROM address walk, remaining-sample count and busy indication.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rom_addr_r  <= {ADDR_W{1'b0}};
            remaining_r <= {ADDR_W{1'b0}};
            sfx_busy_r  <= {NUM_SFX{1'b0}};
        end else if (grant_s) begin
            rom_addr_r  <= base_s;
            remaining_r <= len_s;
            sfx_busy_r  <= arb_grant_s;
        end else if (advance_s) begin
            rom_addr_r  <= rom_addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - ADDR_W'(1);
        end else if (finish_s) begin
            sfx_busy_r  <= {NUM_SFX{1'b0}};
        end
    end

    // ROM latency counter, restarted whenever a new address is issued.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lat_cnt_r <= {LAT_W{1'b0}};
        end else if (grant_s || advance_s) begin
            lat_cnt_r <= {LAT_W{1'b0}};
        end else if ((state_r == FETCH) && !capture_s) begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1);
        end
    end

    // Sample capture (vol applied here only) and output mux select.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sfx_sample_r <= 24'h000000;
            sfx_sel_r    <= 1'b0;
        end else if (capture_s) begin
            sfx_sample_r <= sfx_convert(rom_data, vol);
            sfx_sel_r    <= 1'b1;
        end else if (finish_s) begin
            sfx_sel_r    <= 1'b0;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign sfx_sample = sfx_sample_r;
    assign sfx_sel    = sfx_sel_r;
    assign sfx_busy   = sfx_busy_r;

endmodule

// File: tb/tb_sfx_playback_sched.sv
// Directed testbench for sfx_playback_sched with a one-register ROM model, so
// rom_data is sampled on the second edge after rom_addr changes (ROM_LAT=2).
module tb_sfx_playback_sched;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [3:0]  sfx_trig;
    logic [2:0]  vol;
    logic        rw_ready;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [23:0] sfx_sample;
    logic        sfx_sel;
    logic [3:0]  sfx_busy;

    logic [15:0] rom_mem [0:16383];
    logic [15:0] rom_q;

    int n_cmp = 0;
    int n_err = 0;
    int n_wait;

    sfx_playback_sched #(
        .NUM_SFX (4),
        .ADDR_W  (14),
        .ROM_LAT (2),
        .DATA_W  (16)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .sfx_trig   (sfx_trig),
        .vol        (vol),
        .rw_ready   (rw_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sfx_sample (sfx_sample),
        .sfx_sel    (sfx_sel),
        .sfx_busy   (sfx_busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom_mem[rom_addr];
    assign rom_data = rom_q;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic consume();
        rw_ready = 1'b1;
        tick();
        rw_ready = 1'b0;
    endtask

    task automatic trig(input logic [3:0] t);
        sfx_trig = t;
        tick();
        sfx_trig = 4'b0000;
    endtask

    task automatic wait_sel(input logic v, input int maxc, output int n);
        n = 0;
        while ((sfx_sel !== v) && (n < maxc)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        sfx_trig = 4'b0000;
        vol      = 3'd0;
        rw_ready = 1'b0;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 16'h0000;
        rom_mem[14'h100] = 16'h8000;
        rom_mem[14'h101] = 16'h1234;
        rom_mem[14'h102] = 16'h7FFF;
        rom_mem[14'h200] = 16'h7FFF;
        rom_mem[14'h201] = 16'hFFFF;
        rom_mem[14'h300] = 16'h0011;
        rom_mem[14'h301] = 16'h0022;
        rom_mem[14'h302] = 16'h0033;
        rom_mem[14'h303] = 16'h0044;
        rom_mem[14'h400] = 16'h0100;
        rom_mem[14'h401] = 16'hFF00;

        tick();
        tick();
        chk("rst_addr",   rom_addr,   14'h0000);
        chk("rst_sample", sfx_sample, 24'h000000);
        chk("rst_sel",    sfx_sel,    1'b0);
        chk("rst_busy",   sfx_busy,   4'b0000);
        reset = 1'b0;
        tick();

        // Reset in the middle of a WAIT for effect 1.
        trig(4'b0010);
        wait_sel(1'b1, 20, n_wait);
        chk("mid_lat",    n_wait,     3);
        chk("mid_busy",   sfx_busy,   4'b0010);
        chk("mid_sample", sfx_sample, 24'h7FFF00);
        #5 reset = 1'b1;
        #1;
        chk("arst_sel",  sfx_sel,  1'b0);
        chk("arst_busy", sfx_busy, 4'b0000);
        chk("arst_addr", rom_addr, 14'h0000);
        rw_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_sel",  sfx_sel,  1'b0);
            chk("post_rst_busy", sfx_busy, 4'b0000);
            chk("post_rst_addr", rom_addr, 14'h0000);
        end
        rw_ready = 1'b0;

        // Effect 0, three samples, sparse rw_ready.
        trig(4'b0001);
        wait_sel(1'b1, 20, n_wait);
        chk("e0_lat",  n_wait,     3);
        chk("e0_addr0", rom_addr,  14'h0100);
        chk("e0_busy", sfx_busy,   4'b0001);
        chk("e0_s0",   sfx_sample, 24'h800000);
        repeat (19) tick();
        chk("e0_hold", sfx_sample, 24'h800000);
        chk("e0_sel_hold", sfx_sel, 1'b1);
        consume();
        chk("e0_addr1", rom_addr, 14'h0101);
        chk("e0_sel_fetch", sfx_sel, 1'b1);
        tick();
        tick();
        chk("e0_s1", sfx_sample, 24'h123400);
        repeat (17) tick();
        consume();
        chk("e0_addr2", rom_addr, 14'h0102);
        tick();
        tick();
        chk("e0_s2", sfx_sample, 24'h7FFF00);
        repeat (17) tick();
        consume();
        chk("e0_end_sel",  sfx_sel,  1'b0);
        chk("e0_end_busy", sfx_busy, 4'b0000);
        repeat (4) tick();
        chk("e0_idle_sel",  sfx_sel,  1'b0);
        chk("e0_idle_busy", sfx_busy, 4'b0000);

        // Simultaneous triggers 1 and 3 with attenuation.
        vol = 3'd3;
        trig(4'b1010);
        wait_sel(1'b1, 20, n_wait);
        chk("e1_busy", sfx_busy,   4'b0010);
        chk("e1_addr", rom_addr,   14'h0200);
        chk("e1_s0",   sfx_sample, 24'h0FFFE0);
        consume();
        tick();
        tick();
        chk("e1_s1",   sfx_sample, 24'hFFFFE0);
        chk("e1_addr1", rom_addr,  14'h0201);
        consume();
        chk("gap_busy", sfx_busy, 4'b0000);
        chk("gap_sel",  sfx_sel,  1'b0);
        tick();
        chk("e3_busy", sfx_busy, 4'b1000);
        chk("e3_addr", rom_addr, 14'h0400);
        chk("e3_sel_fetch", sfx_sel, 1'b0);
        tick();
        tick();
        chk("e3_sel", sfx_sel,    1'b1);
        chk("e3_s0",  sfx_sample, 24'h002000);
        vol = 3'd0;
        repeat (3) tick();
        chk("e3_vol_held", sfx_sample, 24'h002000);
        consume();
        tick();
        tick();
        chk("e3_s1", sfx_sample, 24'hFF0000);
        consume();
        chk("e3_end_busy", sfx_busy, 4'b0000);
        chk("e3_end_sel",  sfx_sel,  1'b0);

        // Continuous rw_ready: one sample every three cycles, no skips.
        rw_ready = 1'b1;
        trig(4'b0100);
        wait_sel(1'b1, 20, n_wait);
        chk("e2_lat", n_wait, 3);
        for (int k = 0; k < 4; k++) begin
            chk("e2c_addr",   rom_addr,   32'h300 + k);
            chk("e2c_sample", sfx_sample, 32'h001100 * (k + 1));
            if (k < 3) begin
                repeat (3) tick();
            end else begin
                tick();
            end
        end
        chk("e2c_end_sel",  sfx_sel,  1'b0);
        chk("e2c_end_busy", sfx_busy, 4'b0000);
        rw_ready = 1'b0;
        tick();

        // Effect 0 requested while effect 2 is playing.
        trig(4'b0100);
        wait_sel(1'b1, 20, n_wait);
        chk("pre_busy", sfx_busy, 4'b0100);
        chk("pre_addr", rom_addr, 14'h0300);
        trig(4'b0001);
        chk("pre_still", sfx_busy, 4'b0100);
        consume();
`ifdef SFX_PREEMPT_EN
        chk("pe_addr", rom_addr, 14'h0100);
        chk("pe_busy", sfx_busy, 4'b0001);
        chk("pe_sel",  sfx_sel,  1'b1);
        tick();
        tick();
        chk("pe_s0", sfx_sample, 24'h800000);
        consume();
        tick();
        tick();
        consume();
        tick();
        tick();
        consume();
        chk("pe_end_sel",  sfx_sel,  1'b0);
        chk("pe_end_busy", sfx_busy, 4'b0000);
        repeat (5) tick();
        chk("pe_no_resume_busy", sfx_busy, 4'b0000);
        chk("pe_no_resume_sel",  sfx_sel,  1'b0);
`else
        chk("np_addr1", rom_addr, 14'h0301);
        chk("np_busy",  sfx_busy, 4'b0100);
        tick();
        tick();
        consume();
        tick();
        tick();
        consume();
        chk("np_addr3", rom_addr, 14'h0303);
        tick();
        tick();
        consume();
        chk("np_end_busy", sfx_busy, 4'b0000);
        chk("np_end_sel",  sfx_sel,  1'b0);
        tick();
        chk("np_e0_busy", sfx_busy, 4'b0001);
        chk("np_e0_addr", rom_addr, 14'h0100);
        tick();
        tick();
        chk("np_e0_s0", sfx_sample, 24'h800000);
        consume();
        tick();
        tick();
        consume();
        tick();
        tick();
        consume();
        chk("np_e0_end_sel",  sfx_sel,  1'b0);
        chk("np_e0_end_busy", sfx_busy, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
